uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (start, 8 data LSB first, stop) with runtime divider.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int DEFAULT_DIV = 106
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_div_we,
  input  logic [31:0]            cfg_div_di,
  output logic [31:0]            cfg_div_do,
  input  logic                   tx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_ready,
  output logic                   ser_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ZERO_LVL = LW'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Divider values below 2 would make a bit shorter than the counter can time.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t          state_r, state_next_s;
  logic [31:0]     cnt_r, cnt_next_s;
  logic [2:0]      bit_r, bit_next_s;
  logic [7:0]      data_r;
  logic [31:0]     div_r, div_lat_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r, level_next_s;
  logic            tx_ready_r, busy_r, ser_tx_r, ser_next_s;
  logic            wr_s, pop_s, bit_end_s;

  assign wr_s       = tx_valid & tx_ready_r;
  assign bit_end_s  = (cnt_r == (div_lat_r - 32'd1));
  assign cfg_div_do = div_r;
  assign tx_ready   = tx_ready_r;
  assign ser_tx     = ser_tx_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

  // Transmitter next state, bit timing, pop decision and next serial level.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r + 32'd1;
    bit_next_s   = bit_r;
    pop_s        = 1'b0;
    ser_next_s   = 1'b1;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = 32'd0;
        if (level_r != ZERO_LVL) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        ser_next_s = 1'b0;
        if (bit_end_s) begin
          cnt_next_s   = 32'd0;
          bit_next_s   = 3'd0;
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        ser_next_s = data_r[bit_r];
        if (bit_end_s) begin
          cnt_next_s = 32'd0;
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            bit_next_s   = bit_r + 3'd1;
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        ser_next_s = even_parity(data_r);
        if (bit_end_s) begin
          cnt_next_s   = 32'd0;
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        ser_next_s = 1'b1;
        if (bit_end_s) begin
          cnt_next_s = 32'd0;
          // Chain straight into the next frame when bytes are waiting.
          if (level_r != ZERO_LVL) begin
            pop_s        = 1'b1;
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        cnt_next_s   = 32'd0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy after this edge's write and pop.
  always_comb begin
    case ({wr_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (resetn && wr_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // State, pointers, divider and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 32'd0;
      bit_r      <= 3'd0;
      data_r     <= 8'd0;
      div_r      <= 32'(DEFAULT_DIV);
      div_lat_r  <= 32'd2;
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      level_r    <= ZERO_LVL;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      ser_tx_r   <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      bit_r      <= bit_next_s;
      ser_tx_r   <= ser_next_s;
      level_r    <= level_next_s;
      tx_ready_r <= (level_next_s != FULL_LVL);
      busy_r     <= (state_next_s != ST_IDLE) || (level_next_s != ZERO_LVL);
      if (pop_s) begin
        data_r    <= mem_r[rd_ptr_r];
        div_lat_r <= clamp_div(div_r);
        rd_ptr_r  <= rd_ptr_r + AW'(1);
      end
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (cfg_div_we) begin
        div_r <= cfg_div_di;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-timeline reference model plus directed literal pins.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int DEFAULT_DIV = 106;
  localparam int CAPN = 1300;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk, resetn, cfg_div_we, tx_valid, tx_ready, ser_tx, busy;
  logic [31:0] cfg_div_di, cfg_div_do;
  logic [7:0]  tx_data;
  logic [4:0]  fifo_level;

  uart_tx_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .resetn(resetn), .cfg_div_we(cfg_div_we), .cfg_div_di(cfg_div_di),
    .cfg_div_do(cfg_div_do), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: queue of bytes and the timeline of the frame in flight
  logic [7:0]  m_q[$];
  logic        m_bits[0:10];
  logic        m_active = 1'b0;
  int          m_j = 0;
  int          m_fdiv = 2;
  logic [31:0] m_div = 32'(DEFAULT_DIV);
  logic        m_ser = 1'b1, m_ready = 1'b1, m_busy = 1'b0;
  int          m_level = 0;

  logic cap_ser [0:CAPN-1];
  logic cap_rdy [0:CAPN-1];
  logic cap_busy[0:CAPN-1];
  int   cap_lvl [0:CAPN-1];
  int   cap_i = CAPN;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       ser_n, ending, pop, wr;
    logic [7:0] b;
    if (!resetn) begin
      m_q.delete();
      m_active = 1'b0;
      m_ser = 1'b1; m_div = 32'(DEFAULT_DIV);
      m_level = 0; m_ready = 1'b1; m_busy = 1'b0;
      return;
    end
    ser_n = 1'b1;
    if (m_active) begin
      m_j++;
      if (m_j >= 1 && m_j <= NB * m_fdiv) ser_n = m_bits[(m_j - 1) / m_fdiv];
    end
    ending = m_active && (m_j == NB * m_fdiv);
    pop = (!m_active || ending) && (m_q.size() > 0);
    if (ending && !pop) m_active = 1'b0;
    wr = tx_valid && m_ready;
    if (pop) begin
      b = m_q.pop_front();
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[1 + i] = b[i];
      m_bits[9] = ^b;
      m_bits[NB - 1] = 1'b1;
      m_fdiv = (m_div < 32'd2) ? 2 : int'(m_div);
      m_j = 0;
      m_active = 1'b1;
    end
    if (wr) m_q.push_back(tx_data);
    if (cfg_div_we) m_div = cfg_div_di;
    m_ser = ser_n;
    m_level = m_q.size();
    m_ready = (m_level != DEPTH);
    m_busy = m_active || (m_level != 0);
  endtask

  // one clock: model follows the edge, outputs compared and captured half a period later
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ser_tx", 32'(ser_tx), 32'(m_ser));
    chk("tx_ready", 32'(tx_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("fifo_level", 32'(fifo_level), 32'(m_level));
    chk("cfg_div_do", cfg_div_do, m_div);
    if (cap_i < CAPN) begin
      cap_ser[cap_i] = ser_tx; cap_rdy[cap_i] = tx_ready;
      cap_busy[cap_i] = busy;  cap_lvl[cap_i] = int'(fifo_level);
    end
    cap_i++;
  endtask

  task automatic wait_quiet();
    int n = 0;
    tx_valid = 1'b0; cfg_div_we = 1'b0;
    while (busy !== 1'b0 && n < 3000) begin step(); n++; end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_div(input logic [31:0] d);
    cfg_div_we = 1'b1; cfg_div_di = d; step(); cfg_div_we = 1'b0;
    chk("div_readback", cfg_div_do, d);
  endtask

  logic [10:0] exp55;
  int zeros;

  initial begin
`ifdef UART_TX_PARITY_EN
    exp55 = 11'b10010101010;
`else
    exp55 = 11'b01010101010;
`endif
    resetn = 1'b0; cfg_div_we = 1'b0; cfg_div_di = 32'd0; tx_valid = 1'b0; tx_data = 8'd0;
    step(); step();
    resetn = 1'b1;
    chk("rst_ser", 32'(ser_tx), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div", cfg_div_do, 32'd106);

    // 0x55 at divider 106; divider rewritten to 20 mid-frame
    tx_valid = 1'b1; tx_data = 8'h55; cap_i = 0; step(); tx_valid = 1'b0;
    for (int k = 1; k <= NB * 106 + 2; k++) begin
      if (k == 500) begin cfg_div_we = 1'b1; cfg_div_di = 32'd20; end
      step();
      cfg_div_we = 1'b0;
      if (k == 500) chk("div_mid_frame", cfg_div_do, 32'd20);
    end
    chk("f55_idle_e1", 32'(cap_ser[1]), 32'd1);
    for (int b = 0; b < NB; b++) begin
      chk("f55_bit_first", 32'(cap_ser[2 + 106 * b]), 32'(exp55[b]));
      chk("f55_bit_last", 32'(cap_ser[1 + 106 * (b + 1)]), 32'(exp55[b]));
    end
    chk("f55_busy_end", 32'(cap_busy[NB * 106]), 32'd1);
    chk("f55_busy_after", 32'(cap_busy[NB * 106 + 1]), 32'd0);
    wait_quiet();

    // next frame uses 20-clock bits
    tx_valid = 1'b1; tx_data = 8'h55; cap_i = 0; step(); tx_valid = 1'b0;
    for (int k = 1; k <= 45; k++) step();
    chk("d20_start_first", 32'(cap_ser[2]), 32'd0);
    chk("d20_start_last", 32'(cap_ser[21]), 32'd0);
    chk("d20_bit0_first", 32'(cap_ser[22]), 32'd1);
    chk("d20_bit0_last", 32'(cap_ser[41]), 32'd1);
    chk("d20_bit1_first", 32'(cap_ser[42]), 32'd0);
    wait_quiet();

    // divider 0 behaves as 2
    set_div(32'd0);
    tx_valid = 1'b1; tx_data = 8'h01; cap_i = 0; step(); tx_valid = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("d0_e1", 32'(cap_ser[1]), 32'd1);
    chk("d0_start_a", 32'(cap_ser[2]), 32'd0);
    chk("d0_start_b", 32'(cap_ser[3]), 32'd0);
    chk("d0_bit0", 32'(cap_ser[4]), 32'd1);
    chk("d0_bit1", 32'(cap_ser[6]), 32'd0);
    wait_quiet();
    set_div(32'd1);
    wait_quiet();

    // 17 back-to-back writes at divider 4
    set_div(32'd4);
    cap_i = 0;
    for (int k = 0; k < 17; k++) begin tx_valid = 1'b1; tx_data = 8'(k * 13 + 1); step(); end
    tx_valid = 1'b0;
    for (int k = 17; k <= 4 * NB + 2; k++) step();
    chk("full_rdy_before", 32'(cap_rdy[15]), 32'd1);
    chk("full_level", 32'(cap_lvl[16]), 32'd16);
    chk("full_rdy_low", 32'(cap_rdy[16]), 32'd0);
    chk("full_rdy_still_low", 32'(cap_rdy[4 * NB]), 32'd0);
    chk("full_rdy_after_pop", 32'(cap_rdy[4 * NB + 1]), 32'd1);
    chk("full_level_after_pop", 32'(cap_lvl[4 * NB + 1]), 32'd15);
    wait_quiet();

    // write coinciding with a pop at level 5
    cap_i = 0;
    for (int k = 0; k < 6; k++) begin tx_valid = 1'b1; tx_data = 8'(8'hC0 + k); step(); end
    for (int k = 6; k <= 4 * NB + 2; k++) begin tx_valid = (k == 4 * NB + 1); step(); end
    tx_valid = 1'b0;
    chk("lvl5_before", 32'(cap_lvl[4 * NB]), 32'd5);
    chk("lvl5_same", 32'(cap_lvl[4 * NB + 1]), 32'd5);
    chk("lvl5_later", 32'(cap_lvl[4 * NB + 2]), 32'd5);
    wait_quiet();

    // reset in the middle of the data bits of 0xA3 with 3 bytes queued
    set_div(32'd8);
    cap_i = 0;
    for (int k = 0; k < 4; k++) begin
      tx_valid = 1'b1; tx_data = (k == 0) ? 8'hA3 : 8'(8'h11 * k); step();
    end
    tx_valid = 1'b0;
    for (int k = 4; k <= 27; k++) step();
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("rst_mid_pre_ser", 32'(cap_ser[27]), 32'd0);
    chk("rst_mid_pre_level", 32'(cap_lvl[27]), 32'd3);
    chk("rst_mid_ser", 32'(cap_ser[28]), 32'd1);
    chk("rst_mid_level", 32'(cap_lvl[28]), 32'd0);
    chk("rst_mid_busy", 32'(cap_busy[28]), 32'd0);
    chk("rst_mid_ready", 32'(cap_rdy[28]), 32'd1);
    chk("rst_mid_div", cfg_div_do, 32'd106);
    for (int k = 29; k <= 228; k++) step();
    zeros = 0;
    for (int k = 29; k <= 228; k++) if (cap_ser[k] !== 1'b1 || cap_busy[k] !== 1'b0) zeros++;
    chk("rst_mid_no_frames", 32'(zeros), 32'd0);

    // randomized traffic, divider writes and occasional resets
    set_div(32'd3);
    for (int k = 0; k < 4000; k++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      cfg_div_we = ($urandom_range(0, 149) == 0);
      cfg_div_di = 32'($urandom_range(0, 7));
      resetn = ($urandom_range(0, 999) != 0);
      step();
    end
    resetn = 1'b1; tx_valid = 1'b0;
    set_div(32'd3);
    wait_quiet();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
